lcd_write_scheduler: RTL and testbench

- Shares the 8-bit character-LCD write bus between two requesters: requester 0 is the init/config sequencer and requester 1 is the page renderer.
- Each requester presents one LCD byte (command or data) per transaction. The block arbitrates round-robin between them.
- For each accepted byte it generates the bus timing: setup, enable pulse, hold, then execution wait. Clear and home commands get an extended wait.
- It sits directly between the page/menu state machine and the LCD pins, replacing hand-stepped enable/data sequences.

---
 rtl/lcd_write_scheduler.sv | 143 ++++++++++++++
 tb/tb_lcd_write_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_scheduler.sv
// Round-robin scheduler for the shared 8-bit character-LCD write bus.
// Each accepted byte gets setup, enable pulse, hold and an execution wait.
module lcd_write_scheduler #(
    parameter int SETUP_CYCLES     = 2,
    parameter int PULSE_CYCLES     = 12,
    parameter int HOLD_CYCLES      = 2,
    parameter int WAIT_CYCLES      = 2000,
    parameter int LONG_WAIT_CYCLES = 82000
) (
    input  logic        fpga_clk_i,
    input  logic        fpga_reset_i,
    input  logic [1:0]  req_valid_i,
    input  logic [1:0]  req_rs_i,
    input  logic [15:0] req_data_i,
    output logic [1:0]  req_ready_o,
    output logic        grant_o,
    output logic        busy_o,
    output logic [7:0]  lcd_data_o,
    output logic        lcd_rs_o,
    output logic        lcd_enable_o
);

    localparam int CNT_W = $clog2(LONG_WAIT_CYCLES + 1);

    // The final wait cycle overlaps the IDLE cycle in which the next byte can be
    // accepted, so the WAIT state itself lasts one cycle less than the wait.
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'((WAIT_CYCLES > 1) ? WAIT_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'((LONG_WAIT_CYCLES > 1) ? LONG_WAIT_CYCLES - 2 : 0);
    localparam logic             SHORT_SKIP = (WAIT_CYCLES == 1);
    localparam logic             LONG_SKIP  = (LONG_WAIT_CYCLES == 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rr_favour_q;
    logic             accept;
    logic             accept_idx;
    logic             is_long;
    logic             wait_skip;
    logic [CNT_W-1:0] wait_load;

    // Clear (0x01) and home (0x02/0x03) commands need the extended execution wait.
    assign is_long   = !lcd_rs_o && (lcd_data_o[7:2] == 6'd0) && (lcd_data_o[1:0] != 2'd0);
    assign wait_skip = is_long ? LONG_SKIP : SHORT_SKIP;
    assign wait_load = is_long ? LONG_LOAD : SHORT_LOAD;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        req_ready_o = 2'b00;
        if (state_q == IDLE && !fpga_reset_i) begin
            case (req_valid_i)
                2'b01:   req_ready_o = 2'b01;
                2'b10:   req_ready_o = 2'b10;
                2'b11:   req_ready_o = rr_favour_q ? 2'b10 : 2'b01;
                default: req_ready_o = 2'b00;
            endcase
        end
        accept     = |(req_ready_o & req_valid_i);
        accept_idx = req_ready_o[1];

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = wait_skip ? IDLE : WAIT;
                    cnt_d   = wait_skip ? '0 : wait_load;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge fpga_clk_i) begin
        if (fpga_reset_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rr_favour_q  <= 1'b0;
            lcd_data_o   <= 8'h00;
            lcd_rs_o     <= 1'b0;
            lcd_enable_o <= 1'b0;
            busy_o       <= 1'b0;
            grant_o      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lcd_enable_o <= (state_d == PULSE);
            busy_o       <= (state_d != IDLE);
            if (accept) begin
                lcd_data_o  <= accept_idx ? req_data_i[15:8] : req_data_i[7:0];
                lcd_rs_o    <= req_rs_i[accept_idx];
                grant_o     <= accept_idx;
                rr_favour_q <= ~accept_idx;
            end
        end
    end

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Scoreboard bench for lcd_write_scheduler: a transaction-level model predicts
// grants and phase timing; a separate monitor checks each enable pulse.
module tb_lcd_write_scheduler;

    localparam int S  = 1;
    localparam int P  = 2;
    localparam int H  = 1;
    localparam int W  = 3;
    localparam int LW = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  valid;
    logic [1:0]  rs_in;
    logic [15:0] data_in;
    logic [1:0]  req_ready;
    logic        grant;
    logic        busy;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_en;

    lcd_write_scheduler #(
        .SETUP_CYCLES    (S),
        .PULSE_CYCLES    (P),
        .HOLD_CYCLES     (H),
        .WAIT_CYCLES     (W),
        .LONG_WAIT_CYCLES(LW)
    ) dut (
        .fpga_clk_i  (clk),
        .fpga_reset_i(rst),
        .req_valid_i (valid),
        .req_rs_i    (rs_in),
        .req_data_i  (data_in),
        .req_ready_o (req_ready),
        .grant_o     (grant),
        .busy_o      (busy),
        .lcd_data_o  (lcd_data),
        .lcd_rs_o    (lcd_rs),
        .lcd_enable_o(lcd_en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic       grant;
        logic [7:0] data;
        logic       rs;
        int         en_start;
        int         busy_end;
    } item_t;

    item_t sb_q[$];

    // Requester stimulus state
    logic       have[2];
    logic       rsv[2];
    logic [7:0] dat[2];
    logic [7:0] refill_dat[2];
    logic       refill    = 1'b0;
    logic       rand_mode = 1'b0;

    // Transaction-level model
    int   free_at = 0;
    int   busy_lo = 0;
    int   busy_hi = -1;
    logic last    = 1'b1;
    logic acc_log[$];

    function automatic bit is_long(input logic r, input logic [7:0] d);
        return !r && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    endfunction

    task automatic step();
        logic [1:0] v;
        logic [1:0] exp_rdy;
        logic       win;
        int         c;
        int         occ;
        item_t      it;
        for (int n = 0; n < 2; n++) begin
            if (refill && !have[n]) begin
                have[n] = 1'b1;
                rsv[n]  = 1'b1;
                dat[n]  = refill_dat[n];
            end
            if (rand_mode) begin
                if (!have[n]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        have[n] = 1'b1;
                        rsv[n]  = 1'($urandom_range(0, 1));
                        dat[n]  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4))
                                                              : 8'($urandom_range(0, 255));
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    have[n] = 1'b0;
                end
            end
        end
        v       = {have[1], have[0]};
        valid   = v;
        rs_in   = {rsv[1], rsv[0]};
        data_in = {dat[1], dat[0]};
        #1;
        c       = cyc;
        exp_rdy = 2'b00;
        if (!rst && c >= free_at) begin
            if (v == 2'b11) exp_rdy = last ? 2'b01 : 2'b10;
            else            exp_rdy = v;
        end
        check("ready", req_ready, exp_rdy);
        check("ready_onehot", 32'($onehot0(req_ready)), 1);
        if (busy) check("ready_while_busy", req_ready, 0);
        check("busy", busy, 32'(c >= busy_lo && c <= busy_hi));
        if (rst) begin
            free_at = 0;
            busy_lo = 0;
            busy_hi = -1;
            last    = 1'b1;
        end else if (exp_rdy != 2'b00) begin
            win         = exp_rdy[1];
            occ         = S + P + H + (is_long(rsv[win], dat[win]) ? LW : W);
            it.grant    = win;
            it.data     = dat[win];
            it.rs       = rsv[win];
            it.en_start = c + 1 + S;
            it.busy_end = c + occ;
            sb_q.push_back(it);
            free_at   = c + occ;
            busy_lo   = c + 1;
            busy_hi   = c + occ - 1;
            last      = win;
            have[win] = 1'b0;
            acc_log.push_back(win);
        end
        @(negedge clk);
    endtask

    task automatic run_idle(input int maxc);
        int k = 0;
        while ((have[0] || have[1] || cyc < free_at) && k < maxc) begin
            step();
            k++;
        end
        if (k >= maxc) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", k);
        end
        step();
    endtask

    task automatic send(input int n, input logic r, input logic [7:0] d);
        have[n] = 1'b1;
        rsv[n]  = r;
        dat[n]  = d;
        run_idle(200);
    endtask

    // Monitor: pops one expected item per enable pulse and checks its timing.
    item_t cur;
    bit    cur_v     = 1'b0;
    logic  prev_en   = 1'b0;
    logic  prev_busy = 1'b0;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            cur_v = 1'b0;
        end else begin
            if (lcd_en === 1'b1 && prev_en !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse: got pulse data %0h expected none", lcd_data);
                end else begin
                    cur   = sb_q.pop_front();
                    cur_v = 1'b1;
                    check("grant", grant, cur.grant);
                    check("data", lcd_data, cur.data);
                    check("rs", lcd_rs, cur.rs);
                    check("pulse_start", cyc, cur.en_start);
                end
            end
            if (cur_v) begin
                if (lcd_en !== 1'b1 && prev_en === 1'b1) check("pulse_end", cyc, cur.en_start + P);
                if (cyc >= cur.en_start && cyc <= cur.en_start + P + H - 1) begin
                    check("data_stable", lcd_data, cur.data);
                    check("rs_stable", lcd_rs, cur.rs);
                end
                if (busy !== 1'b1 && prev_busy === 1'b1) begin
                    check("busy_end", cyc, cur.busy_end);
                    cur_v = 1'b0;
                end
            end
        end
        prev_en   = lcd_en;
        prev_busy = busy;
    end

    initial begin
        logic g;
        int   k;
        have[0] = 1'b0; have[1] = 1'b0;
        rsv[0]  = 1'b0; rsv[1]  = 1'b0;
        dat[0]  = 8'h00; dat[1] = 8'h00;
        valid   = 2'b11;
        rs_in   = 2'b11;
        data_in = 16'hffff;
        repeat (3) @(negedge clk);
        check("rst_data", lcd_data, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_enable", lcd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_ready", req_ready, 0);
        rst = 1'b0;

        // Short data write, then long/short command classification
        send(0, 1'b1, 8'h48);
        send(0, 1'b0, 8'h01);
        send(0, 1'b0, 8'h02);
        send(0, 1'b0, 8'h03);
        send(0, 1'b0, 8'h00);
        send(0, 1'b0, 8'h04);
        send(0, 1'b1, 8'h01);

        // Requester 1 alone
        send(1, 1'b1, 8'h31);
        send(1, 1'b1, 8'h32);
        send(1, 1'b1, 8'h33);

        // Reset in the middle of an enable pulse
        have[0] = 1'b1; rsv[0] = 1'b1; dat[0] = 8'h55;
        k = 0;
        while (!(busy_hi >= 0 && cyc == busy_lo + S) && k < 50) begin
            step();
            k++;
        end
        check("pre_reset_enable", lcd_en, 1);
        refill_dat[0] = 8'h41;
        refill_dat[1] = 8'h42;
        refill = 1'b1;
        rst    = 1'b1;
        sb_q.delete();
        step();
        check("mid_rst_enable", lcd_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", lcd_data, 0);
        check("mid_rst_grant", grant, 0);
        step();
        rst = 1'b0;
        acc_log.delete();

        // Both requesters continuously valid: strict alternation starting at 0
        k = 0;
        while (acc_log.size() < 4 && k < 200) begin
            step();
            k++;
        end
        refill = 1'b0;
        have[0] = 1'b0; have[1] = 1'b0;
        run_idle(200);
        for (int i = 0; i < 4; i++) begin
            g = (i < acc_log.size()) ? acc_log[i] : 1'bx;
            check("rr_order", g, i % 2);
        end

        // Random valid toggling
        rand_mode = 1'b1;
        repeat (1500) step();
        rand_mode = 1'b0;
        run_idle(400);
        step();
        check("sb_empty", sb_q.size(), 0);
        check("no_open_item", cur_v, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
